// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: one binary value per request -> packed BCD digits, BIN_W+2 cycles each.
// Define SATURATE_EN to clamp out-of-range results to all-nines; otherwise the result wraps mod 10^DIGITS.
module bin_to_bcd_serial #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  overflow
);

    // Scratch carries one spare digit above the displayed ones so overflow is visible.
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int SR_W  = SCR_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

`ifdef SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 accept;
    logic [SR_W-1:0]      sr_p0;
    logic [SR_W-1:0]      sr_next;
    logic [SCR_W-1:0]     scr_next;
    logic                 ovf_next;
    logic [4*DIGITS-1:0]  bcd_next;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (adj[BIN_W+4*k +: 4] >= 4'd5)
                adj[BIN_W+4*k +: 4] = adj[BIN_W+4*k +: 4] + 4'd3;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [4*DIGITS-1:0] saturate(input logic [4*DIGITS-1:0] low,
                                                     input logic ovf);
        return (SAT_EN && ovf) ? {DIGITS{4'h9}} : low;
    endfunction

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;

    assign sr_next  = dabble_step(sr_p0);
    assign scr_next = sr_next[SR_W-1 -: SCR_W];
    assign ovf_next = |scr_next[SCR_W-1 -: 4];
    assign bcd_next = saturate(scr_next[4*DIGITS-1:0], ovf_next);

    // Stage p0: shift register, loaded on accept and stepped once per SHIFT cycle.
    always_ff @(posedge clock_50Mhz) begin
        if (accept)
            sr_p0 <= {{SCR_W{1'b0}}, bin_in};
        else if (state == SHIFT)
            sr_p0 <= sr_next;
    end

    // Control and output registers; the result is captured on the final shift so
    // bcd_out and out_valid change together and never expose partial values.
    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        bit_cnt <= CNT_W'(BIN_W - 1);
                    end
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        state     <= DONE;
                        bcd_out   <= bcd_next;
                        overflow  <= ovf_next;
                        out_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: arithmetic reference model checked every cycle, plus directed cases.
`timescale 1ns/1ps
module tb_bin_to_bcd_serial;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic              clock_50Mhz = 1'b0;
    logic              reset       = 1'b1;
    logic [BIN_W-1:0]  bin_in      = '0;
    logic              in_valid    = 1'b0;
    logic              in_ready;
    logic [15:0]       bcd_out;
    logic              out_valid;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #10 clock_50Mhz = ~clock_50Mhz;

    bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset       (reset),
        .bin_in      (bin_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bcd_out     (bcd_out),
        .out_valid   (out_valid),
        .overflow    (overflow)
    );

    function automatic logic [15:0] exp_bcd(input int v);
        int r;
`ifdef SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        r = v % 10000;
        return 16'(((r / 1000) << 12) | (((r / 100) % 10) << 8) | (((r / 10) % 10) << 4) | (r % 10));
    endfunction

    function automatic logic exp_ovf(input int v);
        return v > 9999;
    endfunction

    // Reference: a request is busy for BIN_W+2 cycles; result appears BIN_W cycles after accept.
    int          m_timer = -1;
    int          m_val   = 0;
    logic        m_ready = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_bcd   = '0;

    always @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            m_timer = -1;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_bcd   = '0;
        end else begin
            m_valid = 1'b0;
            if (m_timer >= 0) begin
                m_timer++;
                if (m_timer == BIN_W) begin
                    m_valid = 1'b1;
                    m_bcd   = exp_bcd(m_val);
                    m_ovf   = exp_ovf(m_val);
                end
                if (m_timer == BIN_W + 1) m_timer = -1;
            end else if (in_valid) begin
                m_timer = 0;
                m_val   = int'(bin_in);
            end
            m_ready = (m_timer < 0);
        end
    end

    always @(negedge clock_50Mhz) begin
        if (cmp_en) begin
            checks++;
            if ({in_ready, out_valid, overflow, bcd_out} !== {m_ready, m_valid, m_ovf, m_bcd}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: got ready=%b valid=%b ovf=%b bcd=%h, expected ready=%b valid=%b ovf=%b bcd=%h",
                         $time, in_ready, out_valid, overflow, bcd_out, m_ready, m_valid, m_ovf, m_bcd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_50Mhz);
        #1;
    endtask

    // One conversion; optionally disturbs bin_in/in_valid while busy.
    task automatic conv(input int v, input bit disturb,
                        output logic [15:0] b, output logic o, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 40) begin
            tick();
            t++;
        end
        bin_in   = BIN_W'(v);
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clock_50Mhz);
            lat++;
            #1;
            in_valid = 1'b0;
            if (disturb && lat >= 3 && lat <= 5) begin
                in_valid = 1'b1;
                bin_in   = BIN_W'($urandom_range(0, 16383));
            end
        end while (!out_valid && lat < 40);
        b = bcd_out;
        o = overflow;
        in_valid = 1'b0;
    endtask

    logic [15:0] b;
    logic        o;
    int          lat;
    int          acc;
    int          acc_cyc[3];
    int          npulse;
    logic [15:0] outs[4];
    int          rst_left;

    initial begin
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        repeat (3) tick();
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b1;
        tick();

        check("model_1234", 32'(exp_bcd(1234)), 32'h1234);
        check("model_9999", 32'(exp_bcd(9999)), 32'h9999);
`ifdef SATURATE_EN
        check("model_12345", 32'(exp_bcd(12345)), 32'h9999);
`else
        check("model_12345", 32'(exp_bcd(12345)), 32'h2345);
`endif
        check("model_ovf_10000", 32'(exp_ovf(10000)), 32'h1);

        conv(0, 1'b0, b, o, lat);
        check("t1_latency", 32'(lat), 32'd15);
        check("t1_bcd", 32'(b), 32'h0000);
        check("t1_ovf", 32'(o), 32'h0);

        conv(1234, 1'b0, b, o, lat);
        check("t2_bcd_1234", 32'(b), 32'h1234);
        check("t2_ovf_1234", 32'(o), 32'h0);
        conv(9999, 1'b0, b, o, lat);
        check("t2_bcd_9999", 32'(b), 32'h9999);
        check("t2_ovf_9999", 32'(o), 32'h0);

        conv(12345, 1'b0, b, o, lat);
`ifdef SATURATE_EN
        check("t4_bcd_12345", 32'(b), 32'h9999);
`else
        check("t4_bcd_12345", 32'(b), 32'h2345);
`endif
        check("t4_ovf_12345", 32'(o), 32'h1);

        conv(4321, 1'b1, b, o, lat);
        check("t6_bcd_held_input", 32'(b), 32'h4321);
        check("t6_latency", 32'(lat), 32'd15);

        // Held request with stepping value.
        while (!in_ready) tick();
        acc = 0;
        npulse = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                if (npulse < 4) outs[npulse] = bcd_out;
                npulse++;
            end
            if (in_ready) begin
                if (acc < 3) begin
                    bin_in   = BIN_W'(acc + 1);
                    in_valid = 1'b1;
                    acc_cyc[acc] = c;
                    acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        check("t3_pulses", 32'(npulse), 32'd3);
        check("t3_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd16);
        check("t3_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd16);
        check("t3_out0", 32'(outs[0]), 32'h0001);
        check("t3_out1", 32'(outs[1]), 32'h0002);
        check("t3_out2", 32'(outs[2]), 32'h0003);

        // Reset mid-conversion.
        conv(8765, 1'b0, b, o, lat);
        while (!in_ready) tick();
        bin_in   = BIN_W'(5678);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clock_50Mhz);
        check("t5_bcd", 32'(bcd_out), 32'h0);
        check("t5_ready", 32'(in_ready), 32'h1);
        check("t5_ovf", 32'(overflow), 32'h0);
        #1 reset = 1'b1;
        npulse = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) npulse++;
            tick();
        end
        check("t5_no_pulse", 32'(npulse), 32'd0);
        check("t5_ready_after", 32'(in_ready), 32'h1);

        // Randomized traffic including range edges, busy-time noise and occasional resets.
        rst_left = 0;
        for (int c = 0; c < 6000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: bin_in = BIN_W'($urandom_range(0, 9999));
                1: bin_in = BIN_W'($urandom_range(10000, 16383));
                2: bin_in = BIN_W'(9999);
                3: bin_in = BIN_W'(10000);
                4: bin_in = BIN_W'(16383);
                default: bin_in = BIN_W'($urandom_range(0, 16383));
            endcase
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                rst_left = 1;
            end
            tick();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
